// File: rtl/fpdiv_pkg.sv
// Shared definitions for the fpdiv control slice: FSM states, multiplier
// operand select codes and the decoded control word.
package fpdiv_pkg;

  localparam int unsigned CNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT_N,
    ST_INIT_D,
    ST_ITER_N,
    ST_ITER_D,
    ST_REM,
    ST_DONE
  } state_t;

  // Multiplier operand-1 selects
  localparam logic [1:0] MUX3_IA    = 2'd0;
  localparam logic [1:0] MUX3_REGC  = 2'd1;
  localparam logic [1:0] MUX3_DENOM = 2'd2;

  // Multiplier operand-2 selects
  localparam logic [1:0] MUX4_NUM   = 2'd0;
  localparam logic [1:0] MUX4_DENOM = 2'd1;
  localparam logic [1:0] MUX4_REGA  = 2'd2;
  localparam logic [1:0] MUX4_REGB  = 2'd3;

  typedef struct packed {
    logic       en_a;
    logic       en_b;
    logic       en_rem;
    logic [1:0] sel_mux3;
    logic [1:0] sel_mux4;
    logic       busy;
    logic       done;
  } ctrl_t;

  // Control word presented while the FSM sits in a given state
  function automatic ctrl_t decode(input state_t st);
    ctrl_t c;
    c = '0;
    case (st)
      ST_INIT_N: begin
        c.en_a     = 1'b1;
        c.sel_mux3 = MUX3_IA;
        c.sel_mux4 = MUX4_NUM;
        c.busy     = 1'b1;
      end
      ST_INIT_D: begin
        c.en_b     = 1'b1;
        c.sel_mux3 = MUX3_IA;
        c.sel_mux4 = MUX4_DENOM;
        c.busy     = 1'b1;
      end
      ST_ITER_N: begin
        c.en_a     = 1'b1;
        c.sel_mux3 = MUX3_REGC;
        c.sel_mux4 = MUX4_REGA;
        c.busy     = 1'b1;
      end
      ST_ITER_D: begin
        c.en_b     = 1'b1;
        c.sel_mux3 = MUX3_REGC;
        c.sel_mux4 = MUX4_REGB;
        c.busy     = 1'b1;
      end
      ST_REM: begin
        c.en_rem   = 1'b1;
        c.sel_mux3 = MUX3_DENOM;
        c.sel_mux4 = MUX4_REGA;
        c.busy     = 1'b1;
      end
      ST_DONE: begin
        c.done     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fpdiv_iter_cnt.sv
// Loadable 3-bit down-counter tracking remaining refinement iterations.
// Saturates at zero rather than wrapping.
import fpdiv_pkg::*;

module fpdiv_iter_cnt (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  // Count register: load wins over decrement, decrement stops at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/fpdiv_ctrl.sv
// Control FSM for the iterative floating-point divider datapath.
// Sequences initial approximation, ITERS refinement pairs, remainder and done.
import fpdiv_pkg::*;

module fpdiv_ctrl #(
  parameter int unsigned ITERS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       rm_in,
  output logic       en_a,
  output logic       en_b,
  output logic       en_rem,
  output logic [1:0] sel_mux3,
  output logic [1:0] sel_mux4,
  output logic       rm,
  output logic       busy,
  output logic       done
);

  state_t           state;
  state_t           state_nxt;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             last_iter;

  fpdiv_iter_cnt u_iter_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (state == ST_INIT_D),
    .dec      (state == ST_ITER_N),
    .load_val (CNT_W'(ITERS)),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // The counter decrements on the same edge that leaves ITER_N, so a
  // current count of 1 means the post-decrement count is 0.
  assign last_iter = (cnt == CNT_W'(1)) || cnt_zero;

  // Next-state selection; abort overrides every transition
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_INIT_N;
      ST_INIT_N: state_nxt = ST_INIT_D;
      ST_INIT_D: state_nxt = ST_ITER_N;
      ST_ITER_N: state_nxt = last_iter ? ST_REM : ST_ITER_D;
      ST_ITER_D: state_nxt = ST_ITER_N;
      ST_REM:    state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  // State, rounding-mode capture and registered control outputs.
  // Outputs are registered from the next-state decode so they equal the
  // Moore decode of the current state without any output glue.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      rm     <= 1'b0;
      ctrl_q <= '0;
    end else begin
      state  <= state_nxt;
      ctrl_q <= decode(state_nxt);
      if ((state == ST_IDLE) && (state_nxt == ST_INIT_N)) rm <= rm_in;
    end
  end

  assign en_a     = ctrl_q.en_a;
  assign en_b     = ctrl_q.en_b;
  assign en_rem   = ctrl_q.en_rem;
  assign sel_mux3 = ctrl_q.sel_mux3;
  assign sel_mux4 = ctrl_q.sel_mux4;
  assign busy     = ctrl_q.busy;
  assign done     = ctrl_q.done;

endmodule

// File: doc/fpdiv_ctrl.md
FPDIV_CTRL -- requirements
Module: fpdiv_ctrl

Interface
REQ-001 Parameter ITERS, default 3, number of numerator-refinement multiplies after initial approximation; legal range 1..7.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high; sampled on rising edge of clk.
REQ-004 start  input  1  request a new divide; sampled only in IDLE.
REQ-005 abort  input  1  synchronous cancel of an in-flight divide.
REQ-006 rm_in  input  1  rounding mode for this divide (1 = RN, 0 = RZ).
REQ-007 en_a  output  1  load enable for datapath quotient register A.
REQ-008 en_b  output  1  load enable for datapath registers B and C (shared).
REQ-009 en_rem  output  1  load enable for datapath remainder register.
REQ-010 sel_mux3  output  2  multiplier operand-1 select: 0 = initial approximation 0.75, 1 = reg C, 2 = denominator.
REQ-011 sel_mux4  output  2  multiplier operand-2 select: 0 = numerator, 1 = denominator, 2 = reg A, 3 = reg B.
REQ-012 rm  output  1  rounding mode held for the datapath for the whole divide.
REQ-013 busy  output  1  high from the cycle after start is accepted through the REM cycle.
REQ-014 done  output  1  one-cycle pulse; datapath result outputs valid in this cycle.

Function
REQ-015 States: IDLE, INIT_N, INIT_D, ITER_N, ITER_D, REM, DONE; single state register.
REQ-016 IDLE & start -> INIT_N; rm_in captured into rm on the same edge.
REQ-017 INIT_N: sel_mux3=0, sel_mux4=0, en_a=1; next INIT_D.
REQ-018 INIT_D: sel_mux3=0, sel_mux4=1, en_b=1; next ITER_N; iteration counter loaded with ITERS.
REQ-019 ITER_N: sel_mux3=1, sel_mux4=2, en_a=1; counter decrements; next ITER_D if post-decrement count != 0, else REM.
REQ-020 ITER_D: sel_mux3=1, sel_mux4=3, en_b=1; next ITER_N.
REQ-021 Ordering: every ITER_N precedes its ITER_D, so A uses C from the previous ITER_D/INIT_D.
REQ-022 REM: sel_mux3=2, sel_mux4=2, en_rem=1; next DONE.
REQ-023 DONE: done=1, all enables 0; next IDLE; start in DONE is ignored.
REQ-024 Outputs en_*, sel_*, busy, done are decoded from the current state only (Moore); rm is registered.
REQ-025 In IDLE and DONE: en_a=en_b=en_rem=0, sel_mux3=0, sel_mux4=0, busy=0.
REQ-026 Latency: start accepted at edge k; done high in cycle k+2*ITERS+3 (ITERS=3: 9 cycles after acceptance).
REQ-027 At most one of en_a, en_b, en_rem high in any cycle.
REQ-028 start while busy is ignored; rm not recaptured.
REQ-029 abort in any non-IDLE state -> IDLE next edge, no done pulse, enables 0 from the next cycle; abort in IDLE has no effect; abort has priority over start.
REQ-030 Counter width 3 bits; never wraps (load ITERS, stop at 0); ITERS=1 gives INIT_N, INIT_D, ITER_N, REM.

Reset
REQ-031 reset high -> state IDLE, counter 0, rm=0, all outputs 0 on the next edge, regardless of state; reset has priority over abort and start.
REQ-032 reset mid-divide produces no done pulse; a start sampled with reset high is discarded.

Structure
REQ-033 Shared package fpdiv_pkg holds the state enum and named select constants (MUX3_IA, MUX3_REGC, MUX3_DENOM, MUX4_NUM, MUX4_DENOM, MUX4_REGA, MUX4_REGB).
REQ-034 One sub-module fpdiv_iter_cnt: 3-bit loadable down-counter with load, dec, zero flag, synchronous reset.
REQ-035 fpdiv_ctrl connects port-for-port to the fpdiv datapath control inputs without glue logic.

Verification
REQ-036 ITERS=3, start pulse with rm_in=1 -> state sequence INIT_N, INIT_D, ITER_N, ITER_D, ITER_N, ITER_D, ITER_N, REM, DONE; done exactly 9 cycles after acceptance; rm=1 throughout.
REQ-037 Closed loop with fpdiv, 6.0/3.0 (0x40C00000/0x40400000), rm=1 -> final_ans=0x40000000 at done; 1.0/3.0 (0x3F800000/0x40400000) -> 0x3EAAAAAB.
REQ-038 start held high continuously -> back-to-back divides with exactly one IDLE cycle between DONE and next INIT_N; no extra done pulses.
REQ-039 abort asserted in the second ITER_N -> IDLE next cycle, no done, enables 0; new start then completes normally in 9 cycles.
REQ-040 reset asserted in ITER_D with abort and start also high -> all outputs 0 next cycle, state IDLE, rm=0.
REQ-041 ITERS=1 build -> done 5 cycles after acceptance; one-hot check on en_a/en_b/en_rem asserted in every cycle of every scenario.
